addsub_accumulator: RTL

- Sequencing and writeback stage wrapped around the team's 4-bit ripple-carry adder/subtractor.
- Accepts operand/op commands over a valid/ready handshake and drives the adder's operand and mode inputs from registers.
- Captures the adder's result and carry-out into an accumulator plus Z/N/C/V flags.
- Presents each completed operation downstream over a second valid/ready handshake.

---
 rtl/addsub_accumulator.sv | 126 ++++++++++++
 1 files changed

// File: rtl/addsub_accumulator.sv
// Sequencing and writeback stage around an external combinational adder/subtractor.
// Commands enter over in_valid/in_ready; each result leaves over out_valid/out_ready.
module addsub_accumulator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_mode,
    input  logic [WIDTH-1:0] add_result,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CMP  = 2'b11
    } op_t;

    state_t           state, state_next;
    op_t              op_q;
    logic [WIDTH-1:0] b_q;
    logic             mode_q;
    logic [WIDTH-1:0] acc;
    logic             accept;
    logic [WIDTH-1:0] bx;
    logic             arith_v;

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment up front keeps this block from inferring a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; in_ready is also gated by reset itself.
    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == RESP);
    end

    assign accept = in_valid && in_ready;

    // Overflow: operands of equal sign producing a result of the opposite sign.
    assign bx      = b_q ^ {WIDTH{mode_q}};
    assign arith_v = (add_a[WIDTH-1] == bx[WIDTH-1]) && (add_result[WIDTH-1] != add_a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_LOAD;
            b_q    <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            op_q   <= op_t'(in_op);
            b_q    <= in_data;
            mode_q <= (in_op == OP_SUB) || (in_op == OP_CMP);
        end
    end

    // Writeback happens only in EXEC, so flags and acc are frozen during RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (state == EXEC) begin
            if (op_q == OP_LOAD) begin
                acc    <= b_q;
                flag_z <= (b_q == '0);
                flag_n <= b_q[WIDTH-1];
                flag_c <= 1'b0;
                flag_v <= 1'b0;
            end else begin
                if (op_q != OP_CMP) begin
                    acc <= add_result;
                end
                flag_z <= (add_result == '0);
                flag_n <= add_result[WIDTH-1];
                flag_c <= add_cout;
                flag_v <= arith_v;
            end
        end
    end

    assign add_a    = acc;
    assign add_b    = b_q;
    assign add_mode = mode_q;
    assign out_acc  = acc;

endmodule
